// File: rtl/emperor_axi_lite_checker.sv
// Passive AXI-Lite protocol checker: watches one slave port and records VALID-hold,
// payload-stability, ordering, depth and timeout violations as sticky flags.
module emperor_axi_lite_checker #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic                en_check,
  input  logic                err_clr,
  input  logic [ADDR_W-1:0]   S_AXI_awaddr,
  input  logic [2:0]          S_AXI_awprot,
  input  logic                S_AXI_awvalid,
  input  logic                S_AXI_awready,
  input  logic [DATA_W-1:0]   S_AXI_wdata,
  input  logic [DATA_W/8-1:0] S_AXI_wstrb,
  input  logic                S_AXI_wvalid,
  input  logic                S_AXI_wready,
  input  logic [1:0]          S_AXI_bresp,
  input  logic                S_AXI_bvalid,
  input  logic                S_AXI_bready,
  input  logic [ADDR_W-1:0]   S_AXI_araddr,
  input  logic [2:0]          S_AXI_arprot,
  input  logic                S_AXI_arvalid,
  input  logic                S_AXI_arready,
  input  logic [DATA_W-1:0]   S_AXI_rdata,
  input  logic [1:0]          S_AXI_rresp,
  input  logic                S_AXI_rvalid,
  input  logic                S_AXI_rready,
  output logic [15:0]         err_flags,
  output logic                err_valid,
  output logic [3:0]          first_err_code,
  output logic [CNT_W-1:0]    aw_pending,
  output logic [CNT_W-1:0]    w_pending,
  output logic [CNT_W-1:0]    ar_pending,
  output logic [31:0]         wr_count,
  output logic [31:0]         rd_count
);

  localparam int STRB_W = DATA_W / 8;
  localparam int AX_PW  = ADDR_W + 3;
  localparam int W_PW   = DATA_W + STRB_W;
  localparam int R_PW   = DATA_W + 2;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic             wr_active, rd_active;
  logic [4:0]       stall_d, stall_q;
  logic [AX_PW-1:0] aw_pay_d, aw_pay_q, ar_pay_d, ar_pay_q;
  logic [W_PW-1:0]  w_pay_d, w_pay_q;
  logic [1:0]       b_pay_d, b_pay_q;
  logic [R_PW-1:0]  r_pay_d, r_pay_q;
  logic [CNT_W-1:0] aw_pend_d, aw_pend_q, w_pend_d, w_pend_q, ar_pend_d, ar_pend_q;
  logic [TMO_W-1:0] wr_tmo_d, wr_tmo_q, rd_tmo_d, rd_tmo_q;
  logic [15:0]      err_now, err_det, err_base, err_flags_d, err_flags_q;
  logic [3:0]       first_err_d, first_err_q;
  logic [31:0]      wr_count_d, wr_count_q, rd_count_d, rd_count_q;

  function automatic logic [CNT_W-1:0] next_pend(input logic [CNT_W-1:0] cnt,
                                                 input logic inc, input logic dec);
    if (inc && !dec)
      return (cnt == MAX_CNT) ? cnt : cnt + CNT_W'(1);
    else if (dec && !inc)
      return (cnt == '0) ? cnt : cnt - CNT_W'(1);
    else
      return cnt;
  endfunction

  assign aw_hs = S_AXI_awvalid && S_AXI_awready;
  assign w_hs  = S_AXI_wvalid  && S_AXI_wready;
  assign b_hs  = S_AXI_bvalid  && S_AXI_bready;
  assign ar_hs = S_AXI_arvalid && S_AXI_arready;
  assign r_hs  = S_AXI_rvalid  && S_AXI_rready;

  assign aw_pay_d = {S_AXI_awaddr, S_AXI_awprot};
  assign w_pay_d  = {S_AXI_wdata, S_AXI_wstrb};
  assign b_pay_d  = S_AXI_bresp;
  assign ar_pay_d = {S_AXI_araddr, S_AXI_arprot};
  assign r_pay_d  = {S_AXI_rdata, S_AXI_rresp};

  assign stall_d = {S_AXI_rvalid  && !S_AXI_rready,
                    S_AXI_arvalid && !S_AXI_arready,
                    S_AXI_bvalid  && !S_AXI_bready,
                    S_AXI_wvalid  && !S_AXI_wready,
                    S_AXI_awvalid && !S_AXI_awready};

  assign wr_active = (aw_pend_q != '0) || (w_pend_q != '0);
  assign rd_active = (ar_pend_q != '0);

  always_comb begin
    aw_pend_d  = next_pend(aw_pend_q, aw_hs, b_hs);
    w_pend_d   = next_pend(w_pend_q,  w_hs,  b_hs);
    ar_pend_d  = next_pend(ar_pend_q, ar_hs, r_hs);
    wr_count_d = wr_count_q + 32'(b_hs);
    rd_count_d = rd_count_q + 32'(r_hs);

    // Timers clear on a response or when nothing is pending, and park at the limit.
    wr_tmo_d = wr_tmo_q;
    if (!wr_active || b_hs)
      wr_tmo_d = '0;
    else if (wr_tmo_q != TMO_MAX)
      wr_tmo_d = wr_tmo_q + TMO_W'(1);
    rd_tmo_d = rd_tmo_q;
    if (!rd_active || r_hs)
      rd_tmo_d = '0;
    else if (rd_tmo_q != TMO_MAX)
      rd_tmo_d = rd_tmo_q + TMO_W'(1);
  end

  always_comb begin
    err_now     = '0;
    err_now[0]  = stall_q[0] && !S_AXI_awvalid;
    err_now[1]  = stall_q[0] && S_AXI_awvalid && (aw_pay_d != aw_pay_q);
    err_now[2]  = stall_q[1] && !S_AXI_wvalid;
    err_now[3]  = stall_q[1] && S_AXI_wvalid && (w_pay_d != w_pay_q);
    err_now[4]  = stall_q[2] && !S_AXI_bvalid;
    err_now[5]  = stall_q[2] && S_AXI_bvalid && (b_pay_d != b_pay_q);
    err_now[6]  = stall_q[3] && !S_AXI_arvalid;
    err_now[7]  = stall_q[3] && S_AXI_arvalid && (ar_pay_d != ar_pay_q);
    err_now[8]  = stall_q[4] && !S_AXI_rvalid;
    err_now[9]  = stall_q[4] && S_AXI_rvalid && (r_pay_d != r_pay_q);
    err_now[10] = S_AXI_bvalid && ((aw_pend_q == '0) || (w_pend_q == '0));
    err_now[11] = S_AXI_rvalid && (ar_pend_q == '0);
    err_now[12] = !b_hs && ((aw_hs && aw_pend_q == MAX_CNT) || (w_hs && w_pend_q == MAX_CNT));
    err_now[13] = !r_hs && ar_hs && (ar_pend_q == MAX_CNT);
    err_now[14] = wr_active && !b_hs && (wr_tmo_q == TMO_LAST);
    err_now[15] = rd_active && !r_hs && (rd_tmo_q == TMO_LAST);
  end

  // A clear in the same cycle as a new error is applied first, so the new error survives.
  always_comb begin
    err_det     = err_now & {16{en_check}};
    err_base    = err_clr ? '0 : err_flags_q;
    err_flags_d = err_base | err_det;
    first_err_d = err_clr ? '0 : first_err_q;
    if ((err_base == '0) && (err_det != '0)) begin
      for (int i = 15; i >= 0; i--) begin
        if (err_det[i]) first_err_d = 4'(i);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      stall_q     <= '0;
      aw_pay_q    <= '0;
      w_pay_q     <= '0;
      b_pay_q     <= '0;
      ar_pay_q    <= '0;
      r_pay_q     <= '0;
      aw_pend_q   <= '0;
      w_pend_q    <= '0;
      ar_pend_q   <= '0;
      wr_tmo_q    <= '0;
      rd_tmo_q    <= '0;
      err_flags_q <= '0;
      first_err_q <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
    end else begin
      stall_q     <= stall_d;
      aw_pay_q    <= aw_pay_d;
      w_pay_q     <= w_pay_d;
      b_pay_q     <= b_pay_d;
      ar_pay_q    <= ar_pay_d;
      r_pay_q     <= r_pay_d;
      aw_pend_q   <= aw_pend_d;
      w_pend_q    <= w_pend_d;
      ar_pend_q   <= ar_pend_d;
      wr_tmo_q    <= wr_tmo_d;
      rd_tmo_q    <= rd_tmo_d;
      err_flags_q <= err_flags_d;
      first_err_q <= first_err_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
    end
  end

  assign err_flags      = err_flags_q;
  assign err_valid      = |err_flags_q;
  assign first_err_code = first_err_q;
  assign aw_pending     = aw_pend_q;
  assign w_pending      = w_pend_q;
  assign ar_pending     = ar_pend_q;
  assign wr_count       = wr_count_q;
  assign rd_count       = rd_count_q;

endmodule

// File: tb/tb_emperor_axi_lite_checker.sv
// Bench for emperor_axi_lite_checker: directed protocol scenarios followed by random
// traffic, every cycle compared against a channel-indexed behavioural model.
module tb_emperor_axi_lite_checker;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAXO   = 4;
  localparam int TMO    = 16;
  localparam int CNT_W  = $clog2(MAXO + 1);

  logic                aclk = 1'b0;
  logic                arst, en_check, err_clr;
  logic [ADDR_W-1:0]   S_AXI_awaddr, S_AXI_araddr;
  logic [2:0]          S_AXI_awprot, S_AXI_arprot;
  logic                S_AXI_awvalid, S_AXI_awready, S_AXI_wvalid, S_AXI_wready;
  logic                S_AXI_bvalid, S_AXI_bready, S_AXI_arvalid, S_AXI_arready;
  logic                S_AXI_rvalid, S_AXI_rready;
  logic [DATA_W-1:0]   S_AXI_wdata, S_AXI_rdata;
  logic [DATA_W/8-1:0] S_AXI_wstrb;
  logic [1:0]          S_AXI_bresp, S_AXI_rresp;
  logic [15:0]         err_flags;
  logic                err_valid;
  logic [3:0]          first_err_code;
  logic [CNT_W-1:0]    aw_pending, w_pending, ar_pending;
  logic [31:0]         wr_count, rd_count;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state: channels indexed AW=0, W=1, B=2, AR=3, R=4.
  int          m_aw, m_w, m_ar, m_wr_wait, m_rd_wait, m_code;
  logic [15:0] m_flags;
  logic [31:0] m_wr, m_rd;
  logic [4:0]  m_stall;
  logic [63:0] m_pay [5];
  logic [4:0]  tb_stall;

  emperor_axi_lite_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .aclk(aclk), .arst(arst), .en_check(en_check), .err_clr(err_clr),
    .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awprot(S_AXI_awprot),
    .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
    .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb),
    .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
    .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
    .S_AXI_araddr(S_AXI_araddr), .S_AXI_arprot(S_AXI_arprot),
    .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
    .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp),
    .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready),
    .err_flags(err_flags), .err_valid(err_valid), .first_err_code(first_err_code),
    .aw_pending(aw_pending), .w_pending(w_pending), .ar_pending(ar_pending),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp_cnt(input int x);
    if (x < 0) return 0;
    if (x > MAXO) return MAXO;
    return x;
  endfunction

  task automatic model_reset();
    m_aw = 0; m_w = 0; m_ar = 0; m_wr_wait = 0; m_rd_wait = 0; m_code = 0;
    m_flags = '0; m_wr = '0; m_rd = '0; m_stall = '0;
    for (int c = 0; c < 5; c++) m_pay[c] = '0;
  endtask

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [4:0]  v, rdy, hs;
    logic [63:0] p [5];
    logic [15:0] det;
    int          nw, nr;
    if (arst) begin
      model_reset();
      return;
    end
    v    = {S_AXI_rvalid, S_AXI_arvalid, S_AXI_bvalid, S_AXI_wvalid, S_AXI_awvalid};
    rdy  = {S_AXI_rready, S_AXI_arready, S_AXI_bready, S_AXI_wready, S_AXI_awready};
    hs   = v & rdy;
    p[0] = 64'({S_AXI_awaddr, S_AXI_awprot});
    p[1] = 64'({S_AXI_wdata, S_AXI_wstrb});
    p[2] = 64'(S_AXI_bresp);
    p[3] = 64'({S_AXI_araddr, S_AXI_arprot});
    p[4] = 64'({S_AXI_rdata, S_AXI_rresp});
    det = '0;
    for (int c = 0; c < 5; c++) begin
      if (m_stall[c] && !v[c]) det[2*c] = 1'b1;
      if (m_stall[c] && v[c] && p[c] != m_pay[c]) det[2*c+1] = 1'b1;
    end
    if (v[2] && (m_aw == 0 || m_w == 0)) det[10] = 1'b1;
    if (v[4] && m_ar == 0) det[11] = 1'b1;
    if (!hs[2] && ((hs[0] && m_aw == MAXO) || (hs[1] && m_w == MAXO))) det[12] = 1'b1;
    if (!hs[4] && hs[3] && m_ar == MAXO) det[13] = 1'b1;
    nw = ((m_aw == 0 && m_w == 0) || hs[2]) ? 0 : ((m_wr_wait + 1 > TMO) ? TMO : m_wr_wait + 1);
    nr = (m_ar == 0 || hs[4]) ? 0 : ((m_rd_wait + 1 > TMO) ? TMO : m_rd_wait + 1);
    if (nw == TMO && m_wr_wait != TMO) det[14] = 1'b1;
    if (nr == TMO && m_rd_wait != TMO) det[15] = 1'b1;
    if (!en_check) det = '0;
    if (err_clr) begin
      m_flags = '0;
      m_code  = 0;
    end
    if (m_flags == '0 && det != '0) begin
      for (int b = 15; b >= 0; b--) if (det[b]) m_code = b;
    end
    m_flags   = m_flags | det;
    m_aw      = clamp_cnt(m_aw + int'(hs[0]) - int'(hs[2]));
    m_w       = clamp_cnt(m_w  + int'(hs[1]) - int'(hs[2]));
    m_ar      = clamp_cnt(m_ar + int'(hs[3]) - int'(hs[4]));
    m_wr      = m_wr + 32'(hs[2]);
    m_rd      = m_rd + 32'(hs[4]);
    m_wr_wait = nw;
    m_rd_wait = nr;
    m_stall   = v & ~rdy;
    for (int c = 0; c < 5; c++) m_pay[c] = p[c];
  endtask

  task automatic tick();
    model_step();
    @(posedge aclk);
    #1;
    checkOutput("err_flags",  32'(err_flags),      32'(m_flags));
    checkOutput("err_valid",  32'(err_valid),      32'(m_flags != '0));
    checkOutput("first_err",  32'(first_err_code), 32'(m_code));
    checkOutput("aw_pending", 32'(aw_pending),     32'(m_aw));
    checkOutput("w_pending",  32'(w_pending),      32'(m_w));
    checkOutput("ar_pending", 32'(ar_pending),     32'(m_ar));
    checkOutput("wr_count",   wr_count,            m_wr);
    checkOutput("rd_count",   rd_count,            m_rd);
  endtask

  task automatic idle_inputs();
    arst = 1'b0; en_check = 1'b1; err_clr = 1'b0;
    S_AXI_awvalid = 1'b0; S_AXI_awready = 1'b0; S_AXI_wvalid = 1'b0; S_AXI_wready = 1'b0;
    S_AXI_bvalid = 1'b0; S_AXI_bready = 1'b0; S_AXI_arvalid = 1'b0; S_AXI_arready = 1'b0;
    S_AXI_rvalid = 1'b0; S_AXI_rready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    arst = 1'b1;
    tick();
    arst = 1'b0;
  endtask

  // Random traffic that mostly honours VALID-hold but breaks it now and then.
  task automatic applyStimulus();
    arst     = ($urandom_range(0, 399) == 0);
    en_check = ($urandom_range(0, 9) != 0);
    err_clr  = ($urandom_range(0, 9) == 0);
    if (!(tb_stall[0] && $urandom_range(0, 7) != 0)) begin
      S_AXI_awvalid = 1'($urandom_range(0, 1));
      S_AXI_awaddr  = 32'($urandom_range(0, 3) * 4);
      S_AXI_awprot  = 3'($urandom_range(0, 1));
    end
    if (!(tb_stall[1] && $urandom_range(0, 7) != 0)) begin
      S_AXI_wvalid = 1'($urandom_range(0, 1));
      S_AXI_wdata  = 32'($urandom_range(0, 3));
      S_AXI_wstrb  = 4'($urandom_range(14, 15));
    end
    if (!(tb_stall[2] && $urandom_range(0, 7) != 0)) begin
      S_AXI_bvalid = ($urandom_range(0, 2) == 0);
      S_AXI_bresp  = 2'($urandom_range(0, 1));
    end
    if (!(tb_stall[3] && $urandom_range(0, 7) != 0)) begin
      S_AXI_arvalid = 1'($urandom_range(0, 1));
      S_AXI_araddr  = 32'($urandom_range(0, 3) * 4);
      S_AXI_arprot  = 3'($urandom_range(0, 1));
    end
    if (!(tb_stall[4] && $urandom_range(0, 7) != 0)) begin
      S_AXI_rvalid = ($urandom_range(0, 2) == 0);
      S_AXI_rdata  = 32'($urandom_range(0, 3));
      S_AXI_rresp  = 2'($urandom_range(0, 1));
    end
    S_AXI_awready = 1'($urandom_range(0, 1));
    S_AXI_wready  = 1'($urandom_range(0, 1));
    S_AXI_bready  = 1'($urandom_range(0, 1));
    S_AXI_arready = 1'($urandom_range(0, 1));
    S_AXI_rready  = 1'($urandom_range(0, 1));
    tb_stall = {S_AXI_rvalid && !S_AXI_rready, S_AXI_arvalid && !S_AXI_arready,
                S_AXI_bvalid && !S_AXI_bready, S_AXI_wvalid && !S_AXI_wready,
                S_AXI_awvalid && !S_AXI_awready};
  endtask

  initial begin
    model_reset();
    tb_stall = '0;
    idle_inputs();
    S_AXI_awaddr = '0; S_AXI_awprot = '0; S_AXI_wdata = '0; S_AXI_wstrb = '0;
    S_AXI_bresp = '0; S_AXI_araddr = '0; S_AXI_arprot = '0; S_AXI_rdata = '0;
    S_AXI_rresp = '0;
    #2;
    do_reset();
    do_reset();
    checkOutput("reset_flags", 32'(err_flags), 32'h0);
    checkOutput("reset_wr_count", wr_count, 32'h0);

    // Single write then single read.
    S_AXI_awvalid = 1'b1; S_AXI_awready = 1'b1; S_AXI_awaddr = 32'h100;
    S_AXI_wvalid = 1'b1; S_AXI_wready = 1'b1; S_AXI_wdata = 32'hCAFE_0001; S_AXI_wstrb = 4'hF;
    tick();
    idle_inputs(); tick();
    S_AXI_bvalid = 1'b1; S_AXI_bready = 1'b1; tick();
    idle_inputs(); S_AXI_arvalid = 1'b1; S_AXI_arready = 1'b1; S_AXI_araddr = 32'h200; tick();
    idle_inputs(); S_AXI_rvalid = 1'b1; S_AXI_rready = 1'b1; S_AXI_rdata = 32'h1234; tick();
    idle_inputs(); tick();
    checkOutput("single_wr_count", wr_count, 32'd1);
    checkOutput("single_rd_count", rd_count, 32'd1);
    checkOutput("single_pending", 32'({aw_pending, w_pending, ar_pending}), 32'h0);
    checkOutput("single_flags", 32'(err_flags), 32'h0);

    // Address changes while AW is stalled.
    S_AXI_awvalid = 1'b1; S_AXI_awready = 1'b0; S_AXI_awaddr = 32'h10; tick();
    S_AXI_awaddr = 32'h14; tick();
    checkOutput("aw_change_flags", 32'(err_flags), 32'h0002);
    checkOutput("aw_change_code", 32'(first_err_code), 32'd1);
    S_AXI_awready = 1'b1; tick();
    idle_inputs(); err_clr = 1'b1; tick();
    checkOutput("clr_flags", 32'(err_flags), 32'h0);
    idle_inputs(); S_AXI_wvalid = 1'b1; S_AXI_wready = 1'b1; tick();
    idle_inputs(); S_AXI_bvalid = 1'b1; S_AXI_bready = 1'b1; tick();
    idle_inputs(); tick();

    // Read overflow, then an unexpected R after draining.
    do_reset();
    S_AXI_arvalid = 1'b1; S_AXI_arready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      S_AXI_araddr = 32'(i * 4);
      tick();
    end
    checkOutput("rd_ovf_flag", 32'(err_flags[13]), 32'd1);
    checkOutput("rd_ovf_pending", 32'(ar_pending), 32'd4);
    idle_inputs(); S_AXI_rvalid = 1'b1; S_AXI_rready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    idle_inputs(); S_AXI_rvalid = 1'b1; S_AXI_rready = 1'b0; tick();
    checkOutput("r_unexp_flag", 32'(err_flags[11]), 32'd1);
    checkOutput("r_unexp_rd_count", rd_count, 32'd4);
    idle_inputs(); tick();

    // Write timeout after exactly TMO cycles.
    do_reset();
    S_AXI_awvalid = 1'b1; S_AXI_awready = 1'b1; S_AXI_wvalid = 1'b1; S_AXI_wready = 1'b1;
    tick();
    idle_inputs();
    for (int k = 1; k <= TMO; k++) begin
      tick();
      if (k == TMO - 1) checkOutput("wr_tmo_early", 32'(err_flags[14]), 32'd0);
      if (k == TMO)     checkOutput("wr_tmo_fire", 32'(err_flags[14]), 32'd1);
    end
    S_AXI_bvalid = 1'b1; S_AXI_bready = 1'b1; tick();
    checkOutput("wr_tmo_w_pending", 32'(w_pending), 32'd0);
    idle_inputs(); tick();

    // VALID drop with checking disabled, then enabled alongside a clear.
    do_reset();
    en_check = 1'b0; S_AXI_wvalid = 1'b1; S_AXI_wready = 1'b0; tick();
    S_AXI_wvalid = 1'b0; tick();
    checkOutput("en_off_flags", 32'(err_flags), 32'h0);
    en_check = 1'b1; S_AXI_wvalid = 1'b1; tick();
    S_AXI_wvalid = 1'b0; err_clr = 1'b1; tick();
    checkOutput("clr_set_flags", 32'(err_flags), 32'h0004);
    checkOutput("clr_set_code", 32'(first_err_code), 32'd2);
    idle_inputs(); tick();

    // Reset in the middle of a stall with two AW outstanding.
    do_reset();
    S_AXI_awvalid = 1'b1; S_AXI_awready = 1'b1; tick(); tick();
    checkOutput("pre_rst_aw_pending", 32'(aw_pending), 32'd2);
    S_AXI_awready = 1'b0; tick();
    arst = 1'b1; tick();
    checkOutput("mid_rst_aw_pending", 32'(aw_pending), 32'd0);
    arst = 1'b0; S_AXI_awvalid = 1'b0; tick();
    checkOutput("post_rst_flags", 32'(err_flags), 32'h0);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/emperor_axi_lite_checker.md
Name: emperor_axi_lite_checker

Overview:
- Synthesizable, passive AXI-Lite protocol checker for the MMIO subsystem.
- Taps one AXI-Lite slave port between the main bus and an MMIO peripheral, and only observes it.
- Checks VALID-hold, payload stability, response ordering, outstanding-depth and timeout rules on all five channels.
- Reports results as sticky error flags, a first-error code and transaction counters, readable by the testbench and by debug logic in silicon.

Parameters:
- ADDR_W, 32, address width of awaddr/araddr.
- DATA_W, 32, data width; must be 32 or 64; wstrb width is DATA_W/8.
- MAX_OUTSTANDING, 4, maximum accepted-but-unresponded transactions per direction.
- TIMEOUT_CYCLES, 1024, cycles a pending transaction may wait for its response; must be ≥2.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the pending counters (derived).

Ports:
- aclk  in  1  clock.
- arst  in  1  reset; synchronous, active-high.
- en_check  in  1  when 0, no new errors are recorded; tracking continues.
- err_clr  in  1  1-cycle pulse; clears err_flags, err_valid and first_err_code.
- S_AXI_awaddr in ADDR_W; S_AXI_awprot in 3; S_AXI_awvalid in 1; S_AXI_awready in 1.
- S_AXI_wdata in DATA_W; S_AXI_wstrb in DATA_W/8; S_AXI_wvalid in 1; S_AXI_wready in 1.
- S_AXI_bresp in 2; S_AXI_bvalid in 1; S_AXI_bready in 1.
- S_AXI_araddr in ADDR_W; S_AXI_arprot in 3; S_AXI_arvalid in 1; S_AXI_arready in 1.
- S_AXI_rdata in DATA_W; S_AXI_rresp in 2; S_AXI_rvalid in 1; S_AXI_rready in 1.
- err_flags  out  16  sticky error bits (see below).
- err_valid  out  1  high while any err_flags bit is set.
- first_err_code  out  4  index of the first error recorded since reset/clear.
- aw_pending, w_pending, ar_pending  out  CNT_W  accepted AW / W / AR not yet responded.
- wr_count, rd_count  out  32  completed B / R handshakes; wrap modulo 2^32.

Behaviour:
- Reset: all outputs, counters, stall history and timeout counters are 0. Reset mid-transaction discards all pending state. In the first cycle after reset, no drop or change check fires.
- Handshake (hs) on a channel = valid && ready sampled at posedge aclk.
- Stall history, per channel X: register stall_X = X_valid && !X_ready, plus the payload, every cycle.
  - Payloads: AW = {awaddr, awprot}; W = {wdata, wstrb}; B = bresp; AR = {araddr, arprot}; R = {rdata, rresp}.
- Errors per channel (AW=0/1, W=2/3, B=4/5, AR=6/7, R=8/9):
  - even bit (VALID_DROP): stall_X registered && !X_valid now.
  - odd bit (PAYLOAD_CHANGE): stall_X registered && X_valid && payload ≠ registered payload.
- Response ordering and depth:
  - bit10 B_UNEXPECTED: bvalid while aw_pending==0 or w_pending==0, using pre-edge counts. B may never complete in the same cycle as its own AW/W.
  - bit11 R_UNEXPECTED: rvalid while ar_pending==0.
  - bit12 WR_OVERFLOW: AW or W hs while that counter == MAX_OUTSTANDING and no B hs in the same cycle. The counter saturates.
  - bit13 RD_OVERFLOW: the same rule for AR / R.
- Pending counters: next = cnt + hs_in − hs_resp.
  - Write: hs_resp = B hs, and it decrements both aw_pending and w_pending.
  - Simultaneous in+resp leaves the count unchanged.
  - An unexpected response does not decrement below 0.
- Timeouts, one counter per direction:
  - Write counter is active while aw_pending|w_pending ≠ 0; read counter while ar_pending ≠ 0.
  - Cleared by a response hs or by the idle condition; otherwise increments.
  - bit14 WR_TIMEOUT / bit15 RD_TIMEOUT set when the counter reaches TIMEOUT_CYCLES; the counter then holds until cleared.
- Recording:
  - A condition detected at edge N appears on err_flags after edge N (1-cycle latency); flags are sticky.
  - Recording requires en_check==1.
  - first_err_code is latched only when err_valid==0; it takes the lowest-indexed bit among the errors in that cycle.
  - err_clr together with a new error in the same cycle: clear, then record the new error (set wins).
- Counting: wr_count += B hs; rd_count += R hs, independent of errors.

Test Plan:
- Single write (AW and W same cycle, B two cycles later), then a single read → wr_count=1, rd_count=1, all pending 0, err_flags=0.
- awvalid=1, awready=0, awaddr changes 0x10→0x14 next cycle → err_flags[1]=1, first_err_code=1; then err_clr → err_flags=0.
- MAX_OUTSTANDING=4: five AR hs with no R → err_flags[13]=1, ar_pending=4. Then rvalid with no pending AR after draining 4 R → err_flags[11]=1, rd_count=4.
- TIMEOUT_CYCLES=16: AW+W accepted, bvalid held low → err_flags[14] set exactly 16 cycles after the accept edge; a B hs then clears the counter and w_pending=0.
- en_check=0, wvalid dropped while stalled → no flag set. Same stimulus with en_check=1 and err_clr in the same cycle → err_flags[2]=1.
- arst asserted with aw_pending=2 mid-stall → next cycle all outputs 0; awvalid low first cycle after reset → no VALID_DROP.
